// File: rtl/note_sequencer.sv
// note_sequencer: steps a sync note ROM, times each note, drives tone divider; NOTE_GAP_EN adds a silent gap after each note
module note_sequencer #(
    parameter int AW       = 6,
    parameter int TW       = 28,
    parameter int DW       = 8,
    parameter int TICK_DIV = 5_000_000,
    parameter int LOOP     = 0,
    parameter int GAP_CYC  = 2_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play,
    input  logic             stop,
    output logic [AW-1:0]    rom_addr,
    input  logic [TW+DW-1:0] rom_data,
    output logic [TW-1:0]    tone_word,
    output logic             tone_en,
    output logic             busy,
    output logic             note_strb,
    output logic             song_done
);
    localparam int CMAX = TICK_DIV > GAP_CYC ? TICK_DIV : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, LOAD, PLAY
`ifdef NOTE_GAP_EN
        , GAP
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              play_h_q, stop_h_q;
    logic [AW-1:0]     addr_q, addr_d;
    logic [TW-1:0]     word_q, word_d;
    logic              en_q, en_d;
    logic              strb_q, strb_d;
    logic              done_q, done_d;
    logic [CW-1:0]     tick_q, tick_d;
    logic [DW-1:0]     dur_q, dur_d;
    logic [TW+DW-1:0]  data_q, data_d;
    logic              play_edge, stop_edge, tick_wrap;
    logic [TW-1:0]     tone;
    logic [DW-1:0]     dur;

    assign play_edge = play & ~play_h_q;
    assign stop_edge = stop & ~stop_h_q;
    assign tick_wrap = tick_q == CW'(TICK_DIV - 1);
    assign tone      = data_q[TW+DW-1:DW];
    assign dur       = data_q[DW-1:0];

    // next-state and datapath: stop overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        en_d    = en_q;
        strb_d  = 1'b0;
        done_d  = 1'b0;
        tick_d  = tick_q;
        dur_d   = dur_q;
        data_d  = data_q;
        if (stop_edge && state_q != IDLE) begin
            state_d = IDLE;
            addr_d  = '0;
            word_d  = '0;
            en_d    = 1'b0;
            tick_d  = '0;
            dur_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (play_edge && !stop_edge) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
                FETCH: state_d = WAIT;
                WAIT: begin
                    data_d  = rom_data;
                    state_d = LOAD;
                end
                LOAD: if (dur == '0) begin
                    addr_d  = '0;
                    state_d = LOOP != 0 ? FETCH : IDLE;
                    done_d  = LOOP == 0;
                    en_d    = LOOP != 0 ? en_q : 1'b0;
                end else begin
                    word_d  = tone;
                    en_d    = tone != '0;
                    dur_d   = dur;
                    tick_d  = '0;
                    strb_d  = 1'b1;
                    state_d = PLAY;
                end
                PLAY: begin
                    tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                    if (tick_wrap) begin
                        dur_d = dur_q - 1'b1;
                        if (dur_q == DW'(1)) begin
                            addr_d = addr_q + 1'b1;
`ifdef NOTE_GAP_EN
                            en_d    = 1'b0;
                            state_d = GAP;
`else
                            state_d = FETCH;
`endif
                        end
                    end
                end
`ifdef NOTE_GAP_EN
                GAP: begin
                    tick_d  = tick_q == CW'(GAP_CYC - 1) ? '0 : tick_q + 1'b1;
                    state_d = tick_q == CW'(GAP_CYC - 1) ? FETCH : GAP;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // state and output registers; reset silences the buzzer immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            play_h_q <= 1'b0;
            stop_h_q <= 1'b0;
            addr_q   <= '0;
            word_q   <= '0;
            en_q     <= 1'b0;
            strb_q   <= 1'b0;
            done_q   <= 1'b0;
            tick_q   <= '0;
            dur_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            play_h_q <= play;
            stop_h_q <= stop;
            addr_q   <= addr_d;
            word_q   <= word_d;
            en_q     <= en_d;
            strb_q   <= strb_d;
            done_q   <= done_d;
            tick_q   <= tick_d;
            dur_q    <= dur_d;
            data_q   <= data_d;
        end
    end

    assign rom_addr  = addr_q;
    assign tone_word = word_q;
    assign tone_en   = en_q;
    assign busy      = state_q != IDLE;
    assign note_strb = strb_q;
    assign song_done = done_q;
endmodule
